// File: rtl/uart_pkg.sv
// uart_pkg: constants, types and helpers shared by the UART transmit and receive controllers.
//   - CLK_HZ       system clock the baud table is computed for
//   - FRAME_BITS   serial frame length (start + 7 data + 3 trailing bits)
//   - BAUD_K_*     bit-time-unit terminal counts; one bit time is k+1 clocks
//   - uart_state_e controller state encoding
//   - baud_k()     baud code -> terminal count
package uart_pkg;

    localparam int unsigned CLK_HZ     = 100_000_000;
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BTU_W      = 19;
    localparam int unsigned BITCNT_W   = 4;

    localparam logic [BTU_W-1:0] BAUD_K_0  = 19'd333333;
    localparam logic [BTU_W-1:0] BAUD_K_1  = 19'd83333;
    localparam logic [BTU_W-1:0] BAUD_K_2  = 19'd41667;
    localparam logic [BTU_W-1:0] BAUD_K_3  = 19'd20833;
    localparam logic [BTU_W-1:0] BAUD_K_4  = 19'd10417;
    localparam logic [BTU_W-1:0] BAUD_K_5  = 19'd5208;
    localparam logic [BTU_W-1:0] BAUD_K_6  = 19'd2604;
    localparam logic [BTU_W-1:0] BAUD_K_7  = 19'd1736;
    localparam logic [BTU_W-1:0] BAUD_K_8  = 19'd868;
    localparam logic [BTU_W-1:0] BAUD_K_9  = 19'd434;
    localparam logic [BTU_W-1:0] BAUD_K_10 = 19'd217;
    localparam logic [BTU_W-1:0] BAUD_K_11 = 19'd109;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } uart_state_e;

    // Codes above 11 saturate to the fastest rate.
    function automatic logic [BTU_W-1:0] baud_k(input logic [3:0] sel);
        logic [BTU_W-1:0] k;
        case (sel)
            4'd0:    k = BAUD_K_0;
            4'd1:    k = BAUD_K_1;
            4'd2:    k = BAUD_K_2;
            4'd3:    k = BAUD_K_3;
            4'd4:    k = BAUD_K_4;
            4'd5:    k = BAUD_K_5;
            4'd6:    k = BAUD_K_6;
            4'd7:    k = BAUD_K_7;
            4'd8:    k = BAUD_K_8;
            4'd9:    k = BAUD_K_9;
            4'd10:   k = BAUD_K_10;
            default: k = BAUD_K_11;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-time-unit counter.
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   k     in   terminal count; one bit time is k+1 clocks
//   doit  in   1 = count, 0 = hold counter at zero
//   btu   out  combinational strobe, high while the count equals k
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BTU_W-1:0] k,
    input  logic             doit,
    output logic             btu
);

    logic [BTU_W-1:0] cnt_q, cnt_d;

    assign btu = (cnt_q == k);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!doit || btu) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller.
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   load      in   write strobe, accepted only while tx_rdy=1
//   out_port  in   byte to transmit
//   baud_sel  in   baud code (see uart_pkg::baud_k)
//   eight     in   1 = 8 data bits, 0 = 7 data bits
//   pen       in   parity enable
//   ohel      in   parity sense, 1 = odd, 0 = even
//   tx        out  serial line, idles high
//   tx_rdy    out  idle and able to accept load
//   tx_done   out  one-cycle pulse at the end of each frame
module uart_tx_ctrl
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] out_port,
    input  logic [3:0] baud_sel,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    output logic       tx,
    output logic       tx_rdy,
    output logic       tx_done
);

    uart_state_e           state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [BTU_W-1:0]      k_q, k_d;
    logic                  done_q, done_d;

    logic                  doit;
    logic                  btu;
    logic                  parity;
    logic                  frame_b8;
    logic                  frame_b9;
    logic [FRAME_BITS-1:0] frame;

    // Frame assembly from the live inputs; only used on the accepting edge.
    always_comb begin
        parity   = (eight ? ^out_port : ^out_port[6:0]) ^ ohel;
        frame_b8 = eight ? out_port[7] : (pen ? parity : 1'b1);
        frame_b9 = (eight && pen) ? parity : 1'b1;
        frame    = {1'b1, frame_b9, frame_b8, out_port[6:0], 1'b0};
    end

    assign doit = (state_q == SEND);

    uart_bit_timer u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .k    (k_q),
        .doit (doit),
        .btu  (btu)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        k_d      = k_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d  = SEND;
                    shreg_d  = frame;
                    bitcnt_d = '0;
                    k_d      = baud_k(baud_sel);
                end
            end
            SEND: begin
                if (btu) begin
                    // One-fill leaves the register all ones after the stop bit,
                    // so tx idles high straight from the shift register.
                    shreg_d  = {1'b1, shreg_q[FRAME_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BITCNT_W'(FRAME_BITS - 1)) begin
                        state_d  = IDLE;
                        bitcnt_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shreg_q  <= '1;
            bitcnt_q <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            k_q      <= k_d;
            done_q   <= done_d;
        end
    end

    // tx comes straight off a flop, never through a mux.
    assign tx      = shreg_q[0];
    assign tx_rdy  = (state_q == IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: self-checking bench for uart_tx_ctrl against a frame/bit-time reference model.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic [3:0] baud_sel = 4'd11;
    logic       eight = 1'b1;
    logic       pen = 1'b0;
    logic       ohel = 1'b0;
    logic       tx;
    logic       tx_rdy;
    logic       tx_done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    uart_tx_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .out_port (out_port),
        .baud_sel (baud_sel),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .tx       (tx),
        .tx_rdy   (tx_rdy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Terminal count straight from the baud table.
    function automatic int unsigned ref_k(input logic [3:0] sel);
        case (sel)
            4'd0:    return 333333;
            4'd1:    return 83333;
            4'd2:    return 41667;
            4'd3:    return 20833;
            4'd4:    return 10417;
            4'd5:    return 5208;
            4'd6:    return 2604;
            4'd7:    return 1736;
            4'd8:    return 868;
            4'd9:    return 434;
            4'd10:   return 217;
            default: return 109;
        endcase
    endfunction

    // Expected 11-bit frame, f[0] first on the wire.
    function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic e,
                                              input logic pn, input logic odd);
        logic [10:0] f;
        int          ones;
        int          nbits;
        logic        p;
        ones  = 0;
        nbits = e ? 8 : 7;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        p    = (ones % 2 == 1) ^ odd;
        f[0] = 1'b0;
        for (int i = 0; i < 7; i++) f[i+1] = d[i];
        f[8]  = e ? d[7] : (pn ? p : 1'b1);
        f[9]  = (e && pn) ? p : 1'b1;
        f[10] = 1'b1;
        return f;
    endfunction

    // Sends one frame and checks every cycle of it. Returns #1 after edge E0+11(k+1),
    // so an immediately following call loads back-to-back at the earliest legal edge.
    // abort_at >= 0 pulls reset at that cycle offset and checks the abort instead.
    task automatic run_frame(input string name, input logic [7:0] d, input logic [3:0] sel,
                             input logic e, input logic pn, input logic odd,
                             input bit disturb, input int abort_at);
        int unsigned kp1;
        int unsigned total;
        logic [10:0] f;
        int          bad_tx[11];
        int          bad_ctl;
        int          bad_idle;
        kp1   = ref_k(sel) + 1;
        total = 11 * kp1;
        f     = ref_frame(d, e, pn, odd);
        for (int i = 0; i < 11; i++) bad_tx[i] = 0;
        bad_ctl = 0;

        @(negedge clk);
        out_port = d;
        baud_sel = sel;
        eight    = e;
        pen      = pn;
        ohel     = odd;
        load     = 1'b1;
        check_val({name, " tx_rdy before load"}, 32'(tx_rdy), 32'd1);
        @(posedge clk);
        #1;
        load = 1'b0;

        for (int c = 0; c < int'(total); c++) begin
            if (abort_at >= 0 && c == abort_at) begin
                #1;
                rst = 1'b0;
                #1;
                check_val({name, " abort tx"}, 32'(tx), 32'd1);
                check_val({name, " abort tx_rdy"}, 32'(tx_rdy), 32'd1);
                check_val({name, " abort tx_done"}, 32'(tx_done), 32'd0);
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst      = 1'b1;
                bad_idle = 0;
                for (int j = 0; j < 2 * int'(total); j++) begin
                    @(posedge clk);
                    #1;
                    if (tx !== 1'b1 || tx_rdy !== 1'b1 || tx_done !== 1'b0) bad_idle++;
                end
                check_val({name, " quiet after abort"}, 32'(bad_idle), 32'd0);
                return;
            end
            if (tx !== f[c / int'(kp1)]) bad_tx[c / int'(kp1)]++;
            if (tx_rdy !== 1'b0 || tx_done !== 1'b0) bad_ctl++;
            if (disturb && c == 3 * int'(kp1) + 7) begin
                load     = 1'b1;
                out_port = 8'h00;
                baud_sel = 4'd0;
                eight    = ~e;
                pen      = ~pn;
                ohel     = ~odd;
            end
            if (disturb && c == 3 * int'(kp1) + 8) load = 1'b0;
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 11; i++) begin
            check_val($sformatf("%s bit%0d wrong cycles (exp level %0d)", name, i, f[i]),
                      32'(bad_tx[i]), 32'd0);
        end
        check_val({name, " busy/done violations"}, 32'(bad_ctl), 32'd0);
        check_val({name, " tx_done at end"}, 32'(tx_done), 32'd1);
        check_val({name, " tx_rdy at end"}, 32'(tx_rdy), 32'd1);
        check_val({name, " tx at end"}, 32'(tx), 32'd1);
    endtask

    initial begin
        int quiet_bad;

        // Reset state, then no activity without load.
        #23;
        check_val("reset tx", 32'(tx), 32'd1);
        check_val("reset tx_rdy", 32'(tx_rdy), 32'd1);
        check_val("reset tx_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        quiet_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || tx_rdy !== 1'b1 || tx_done !== 1'b0) quiet_bad++;
        end
        check_val("idle without load", 32'(quiet_bad), 32'd0);

        // Directed frames at k=109, back-to-back.
        run_frame("8N1 A5", 8'hA5, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        run_frame("8O1 03", 8'h03, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        run_frame("8E1 03", 8'h03, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        run_frame("7E1 FF", 8'hFF, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run_frame("disturbed 5C", 8'h5C, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        @(posedge clk);
        #1;
        check_val("tx_done drops", 32'(tx_done), 32'd0);

        // Reset at bit 4, then a clean frame.
        run_frame("abort", 8'h96, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 4 * 110 + 55);
        run_frame("after abort", 8'h96, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, -1);

        // Randomized frames at the faster baud codes, with random idle gaps.
        for (int n = 0; n < 8; n++) begin
            logic [7:0] rd;
            logic [3:0] rs;
            logic [2:0] cfg;
            rd  = 8'($urandom);
            rs  = 4'($urandom_range(10, 15));
            cfg = 3'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_frame($sformatf("rand%0d d=%02h sel=%0d cfg=%0d", n, rd, rs, cfg),
                      rd, rs, cfg[0], cfg[1], cfg[2], 1'b0, -1);
        end

        @(posedge clk);
        #1;
        check_val("final tx_done low", 32'(tx_done), 32'd0);
        check_val("final tx_rdy", 32'(tx_rdy), 32'd1);
        check_val("final tx", 32'(tx), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
